// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one 4-bit combinational ALU between NUM_REQ requesters.
//
// Each requester hands over {a, b, op} with a valid/ready request. The winning operation
// is driven onto the ALU and held for SETTLE_CYCLES cycles, so that post-layout
// propagation has settled. The result is then captured and returned with a valid/ready
// response. Only one operation is in flight at a time.
//
// Optional build macro:
//   ALU_ARB_PRIO0_EN - requester 0 has fixed highest priority; round-robin applies
//                      among requesters 1..NUM_REQ-1. When undefined, round-robin
//                      applies over all requesters.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready per-requester request handshake (ready is one-hot, combinational)
//   req_a/req_b         4-bit operands, requester i at [4i+3:4i]
//   req_op              {ctrl1, ctrl0}, requester i at [2i+1:2i]
//   resp_valid          one-hot result valid for the granted requester
//   resp_ready          per-requester result accept
//   resp_c/resp_ovf     captured ALU result / overflow
//   alu_a/alu_b/alu_ctrl0/alu_ctrl1  held operands to the ALU macro
//   alu_c/alu_ovf       ALU result inputs
//   busy                high whenever an operation is in flight
//   grant_id            index of the current/last granted requester
module alu_req_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [3:0]           resp_c,
  output logic                 resp_ovf,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic                 alu_ctrl0,
  output logic                 alu_ctrl1,
  input  logic [3:0]           alu_c,
  input  logic                 alu_ovf,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] OneHot0 = {{(NUM_REQ - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        last_q;
  logic [2:0]        grant_q;
  logic [3:0]        alu_a_q, alu_b_q;
  logic [1:0]        alu_op_q;
  logic [3:0]        resp_c_q;
  logic              resp_ovf_q;

  logic [NUM_REQ-1:0]   cand, hi_mask, pick, grant_oh;
  logic [2:0]           sel;
  logic [4*NUM_REQ-1:0] a_shift, b_shift;
  logic [2*NUM_REQ-1:0] op_shift;
  logic                 load_op, capture, done;

  // Arbitration: prefer candidates above the last winner, otherwise wrap to the lowest
  // set bit. Lowest-set-bit isolation (x & -x) gives the one-hot winner.
  always_comb begin
    cand = req_valid;
`ifdef ALU_ARB_PRIO0_EN
    cand = req_valid & ~OneHot0;
`endif
    // Bits strictly above last_q; all-zero when last_q is the top index.
    hi_mask  = ~(((OneHot0 << last_q) << 1) - OneHot0);
    pick     = (|(cand & hi_mask)) ? (cand & hi_mask) : cand;
    grant_oh = pick & (~pick + OneHot0);
`ifdef ALU_ARB_PRIO0_EN
    if (req_valid[0]) grant_oh = OneHot0;
`endif
    sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh == (OneHot0 << i)) sel = 3'(i);
    end
    a_shift  = req_a >> {sel, 2'b00};
    b_shift  = req_b >> {sel, 2'b00};
    op_shift = req_op >> {sel, 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    load_op   = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|grant_oh) begin
          req_ready = grant_oh;
          load_op   = 1'b1;
          cnt_d     = CntLoad;
          state_d   = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StCapture;
        else cnt_d = cnt_q - 1'b1;
      end
      StCapture: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        // resp_valid is one-hot on grant_q, so other requesters' resp_ready is masked out.
        if (|(resp_valid & resp_ready)) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_q     <= 3'(NUM_REQ - 1);
      grant_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      resp_c_q   <= '0;
      resp_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_op) begin
        grant_q  <= sel;
        alu_a_q  <= a_shift[3:0];
        alu_b_q  <= b_shift[3:0];
        alu_op_q <= op_shift[1:0];
      end
      if (capture) begin
        resp_c_q   <= alu_c;
        resp_ovf_q <= alu_ovf;
      end
      if (done) last_q <= grant_q;
    end
  end

  assign resp_valid = (state_q == StResp) ? (OneHot0 << grant_q) : '0;
  assign busy       = (state_q != StIdle);
  assign grant_id   = grant_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl0  = alu_op_q[0];
  assign alu_ctrl1  = alu_op_q[1];
  assign resp_c     = resp_c_q;
  assign resp_ovf   = resp_ovf_q;

endmodule
